alu_ctrl_sequencer: RTL and testbench

//  Multi-cycle control sequencer that sits directly upstream of reg_file_alu.

---
 rtl/alu_ctrl_pkg.sv | 56 +++++
 rtl/instr_decode.sv | 55 +++++
 rtl/alu_ctrl_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_ctrl_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// Module      : alu_ctrl_pkg
// Description : Shared types and constants for the ALU control sequencer:
//               opcode and FSM state encodings, ALU function codes and
//               instruction field bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

   // Instruction opcodes (op field). 9..E are illegal.
   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_AND  = 4'h3,
      OP_OR   = 4'h4,
      OP_ADDI = 4'h5,
      OP_SUBI = 4'h6,
      OP_JMP  = 4'h7,
      OP_JNZ  = 4'h8,
      OP_HALT = 4'hF
   } op_e;

   // ALUControl encodings understood by reg_file_alu
   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_OR  = 2'b11;

   // Instruction word layout: op | rd | rs1 | rs2 | imm
   localparam int INSTR_W = 24;
   localparam int OP_MSB  = 23;
   localparam int OP_LSB  = 20;
   localparam int RD_MSB  = 19;
   localparam int RD_LSB  = 16;
   localparam int RS1_MSB = 15;
   localparam int RS1_LSB = 12;
   localparam int RS2_MSB = 11;
   localparam int RS2_LSB = 8;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   // Sequencer FSM states
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_WRITE  = 3'd4
   } state_e;

endpackage : alu_ctrl_pkg

`default_nettype wire

// File: rtl/instr_decode.sv
// ============================================================================
// Module      : instr_decode
// Description : Combinational opcode decoder for the ALU control sequencer.
// Ports       : op           in   4  opcode field of the instruction
//               alu_op_valid out  1  instruction writes a register (needs WRITE)
//               alu_src      out  1  ALU operand B comes from the immediate
//               alu_control  out  2  ALU function code
//               is_jmp       out  1  unconditional jump
//               is_jnz       out  1  jump if rs1 != 0
//               is_halt      out  1  end of program
//               illegal      out  1  opcode 9..E
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decode
   import alu_ctrl_pkg::*;
(
   input  logic [3:0] op,
   output logic       alu_op_valid,
   output logic       alu_src,
   output logic [1:0] alu_control,
   output logic       is_jmp,
   output logic       is_jnz,
   output logic       is_halt,
   output logic       illegal
);

   always_comb begin
      alu_op_valid = 1'b0;
      alu_src      = 1'b0;
      alu_control  = ALU_ADD;
      is_jmp       = 1'b0;
      is_jnz       = 1'b0;
      is_halt      = 1'b0;
      illegal      = 1'b0;
      case (op)
         OP_NOP:  ;
         OP_ADD:  alu_op_valid = 1'b1;
         OP_SUB:  begin alu_op_valid = 1'b1; alu_control = ALU_SUB; end
         OP_AND:  begin alu_op_valid = 1'b1; alu_control = ALU_AND; end
         OP_OR:   begin alu_op_valid = 1'b1; alu_control = ALU_OR;  end
         OP_ADDI: begin alu_op_valid = 1'b1; alu_src = 1'b1; end
         OP_SUBI: begin alu_op_valid = 1'b1; alu_src = 1'b1; alu_control = ALU_SUB; end
         OP_JMP:  is_jmp = 1'b1;
         // JNZ tests rs1 by running rs1 + 0 through the ALU
         OP_JNZ:  begin is_jnz = 1'b1; alu_src = 1'b1; end
         OP_HALT: is_halt = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

endmodule : instr_decode

`default_nettype wire

// File: rtl/alu_ctrl_sequencer.sv
// ============================================================================
// Module      : alu_ctrl_sequencer
// Description : Multi-cycle control sequencer in front of reg_file_alu.
//               Fetches 24-bit instructions from a synchronous ROM, decodes
//               them and drives register addresses, write enable and ALU
//               controls. ALUResult is read back to resolve JNZ.
// Ports       : clk, reset (async, active-low)
//               start / busy / done / error   run handshake and status
//               imem_addr / imem_rdata          instruction ROM (1-cycle read)
//               RA1, RA2, WA, RegWrite, ALUSrc, ALUControl,
//               external_data_in                datapath controls
//               ALUResult                       datapath result
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ctrl_sequencer
   import alu_ctrl_pkg::*;
#(
   parameter int PC_W   = 8,
   parameter int DATA_W = 8,
   parameter int REG_AW = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               error,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [REG_AW-1:0]  RA1,
   output logic [REG_AW-1:0]  RA2,
   output logic [REG_AW-1:0]  WA,
   output logic               RegWrite,
   output logic               ALUSrc,
   output logic [1:0]         ALUControl,
   output logic [DATA_W-1:0]  external_data_in,
   input  logic [DATA_W-1:0]  ALUResult
);

   state_e             state;
   logic [PC_W-1:0]    pc;
   logic [INSTR_W-1:0] ir;

   logic [3:0] dec_op;
   logic       alu_op_valid;
   logic       alu_src;
   logic [1:0] alu_control;
   logic       is_jmp;
   logic       is_jnz;
   logic       is_halt;
   logic       illegal;

   // Operand fields of ir are consumed straight from imem_rdata in DECODE.
   logic unused_ir_bits;
   assign unused_ir_bits = ^ir[RS1_MSB:RS2_LSB];

   // pc is a register, so the ROM address is a registered output.
   assign imem_addr = pc;

   // In DECODE the instruction is still on imem_rdata (ir loads at the end
   // of that cycle); afterwards the decoder looks at the held ir.
   assign dec_op = (state == S_DECODE) ? imem_rdata[OP_MSB:OP_LSB] : ir[OP_MSB:OP_LSB];

   instr_decode u_decode (
      .op           (dec_op),
      .alu_op_valid (alu_op_valid),
      .alu_src      (alu_src),
      .alu_control  (alu_control),
      .is_jmp       (is_jmp),
      .is_jnz       (is_jnz),
      .is_halt      (is_halt),
      .illegal      (illegal)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state            <= S_IDLE;
         pc               <= '0;
         ir               <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         error            <= 1'b0;
         RA1              <= '0;
         RA2              <= '0;
         WA               <= '0;
         RegWrite         <= 1'b0;
         ALUSrc           <= 1'b0;
         ALUControl       <= ALU_ADD;
         external_data_in <= '0;
      end else begin
         done     <= 1'b0;
         RegWrite <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  pc    <= '0;
                  error <= 1'b0;
                  busy  <= 1'b1;
                  state <= S_FETCH;
               end
            end
            S_FETCH: begin
               state <= S_DECODE;
            end
            S_DECODE: begin
               ir <= imem_rdata;
               if (is_halt || illegal) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  if (illegal) error <= 1'b1;
                  state <= S_IDLE;
               end else begin
                  // Operands are set up here so they are stable for all of
                  // EXEC and WRITE.
                  RA1              <= REG_AW'(imem_rdata[RS1_MSB:RS1_LSB]);
                  RA2              <= REG_AW'(imem_rdata[RS2_MSB:RS2_LSB]);
                  ALUSrc           <= alu_src;
                  ALUControl       <= alu_control;
                  external_data_in <= is_jnz ? '0 : DATA_W'(imem_rdata[IMM_MSB:IMM_LSB]);
                  state            <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (alu_op_valid) begin
                  WA       <= REG_AW'(ir[RD_MSB:RD_LSB]);
                  RegWrite <= 1'b1;
                  state    <= S_WRITE;
               end else begin
                  if (is_jmp || (is_jnz && (ALUResult != '0)))
                     pc <= PC_W'(ir[IMM_MSB:IMM_LSB]);
                  else
                     pc <= pc + PC_W'(1);
                  state <= S_FETCH;
               end
            end
            S_WRITE: begin
               pc    <= pc + PC_W'(1);
               state <= S_FETCH;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule : alu_ctrl_sequencer

`default_nettype wire

// File: tb/tb_alu_ctrl_sequencer.sv
// ============================================================================
// Module      : tb_alu_ctrl_sequencer
// Description : Self-checking bench for alu_ctrl_sequencer with a behavioural
//               reg_file_alu and a synchronous instruction ROM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_ctrl_sequencer;
   import alu_ctrl_pkg::*;

   localparam int PC_W   = 8;
   localparam int DATA_W = 8;
   localparam int REG_AW = 4;

   logic              clk   = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic              busy, done, error, RegWrite, ALUSrc;
   logic [PC_W-1:0]   imem_addr;
   logic [23:0]       imem_rdata;
   logic [REG_AW-1:0] RA1, RA2, WA;
   logic [1:0]        ALUControl;
   logic [DATA_W-1:0] external_data_in, ALUResult;

   alu_ctrl_sequencer #(.PC_W(PC_W), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .busy             (busy),
      .done             (done),
      .error            (error),
      .imem_addr        (imem_addr),
      .imem_rdata       (imem_rdata),
      .RA1              (RA1),
      .RA2              (RA2),
      .WA               (WA),
      .RegWrite         (RegWrite),
      .ALUSrc           (ALUSrc),
      .ALUControl       (ALUControl),
      .external_data_in (external_data_in),
      .ALUResult        (ALUResult)
   );

   always #5 clk = ~clk;

   // Synchronous instruction ROM
   logic [23:0] rom [0:255];
   always @(posedge clk) imem_rdata <= rom[imem_addr];

   // Behavioural reg_file_alu
   logic [DATA_W-1:0] regs [0:15];
   logic [DATA_W-1:0] op_b;
   always_comb begin
      op_b = ALUSrc ? external_data_in : regs[RA2];
      case (ALUControl)
         2'b00:   ALUResult = regs[RA1] + op_b;
         2'b01:   ALUResult = regs[RA1] - op_b;
         2'b10:   ALUResult = regs[RA1] & op_b;
         default: ALUResult = regs[RA1] | op_b;
      endcase
   end
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) regs[i] <= '0;
      end else if (RegWrite) begin
         regs[WA] <= ALUResult;
      end
   end

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // Scoreboard of expected register writes
   typedef struct packed {
      logic [3:0] wa;
      logic [7:0] data;
   } wr_t;
   wr_t exp_q[$];
   wr_t e;

   int n_tests = 0;
   int n_fail  = 0;
   int wr_cnt  = 0;
   int unexpected_wr = 0;
   bit done_seen = 1'b0;
   int t0 = 0;

   function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endfunction

   always @(negedge clk) begin
      if (reset === 1'b1 && done === 1'b1) done_seen = 1'b1;
      if (reset === 1'b1 && RegWrite === 1'b1) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            unexpected_wr++;
         end else begin
            e = exp_q.pop_front();
            check("write_wa", WA, e.wa);
            check("write_data", ALUResult, e.data);
         end
      end
   end

   function automatic logic [23:0] enc(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs1, input logic [3:0] rs2,
                                       input logic [7:0] imm);
      return {op, rd, rs1, rs2, imm};
   endfunction

   task automatic load_prog1();
      rom[0] = enc(4'h5, 4'd1, 4'd0, 4'd0, 8'd5);   // ADDI r1,r0,5
      rom[1] = enc(4'h5, 4'd2, 4'd0, 4'd0, 8'd3);   // ADDI r2,r0,3
      rom[2] = enc(4'h1, 4'd3, 4'd1, 4'd2, 8'd0);   // ADD  r3,r1,r2
      rom[3] = enc(4'hF, 4'd0, 4'd0, 4'd0, 8'd0);   // HALT
   endtask

   task automatic do_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      t0 = cyc_cnt;
      check("busy_rise", busy, 1);
      check("error_clear", error, 0);
   endtask

   // Latency = clock edges from busy rising to done being visible.
   task automatic wait_done(input string tag, input int exp_cycles);
      int n;
      n = 0;
      while (done !== 1'b1 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, done, 1);
      check({tag, "_latency"}, cyc_cnt - t0, exp_cycles);
      check({tag, "_busy_low"}, busy, 0);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 256; i++) rom[i] = 24'h0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_regwrite", RegWrite, 0);
      check("rst_imem_addr", imem_addr, 0);
      check("rst_ctrl", {RA1, RA2, WA, ALUSrc, ALUControl, external_data_in}, 0);
      reset = 1'b1;

      // 1: straight-line ALU program, 3 x 4 cycles + HALT fetch/decode
      load_prog1();
      exp_q.push_back({4'd1, 8'd5});
      exp_q.push_back({4'd2, 8'd3});
      exp_q.push_back({4'd3, 8'd8});
      wr_cnt = 0;
      do_start();
      wait_done("t1", 14);
      check("t1_r3", regs[3], 8);
      check("t1_error", error, 0);
      check("t1_wr_cnt", wr_cnt, 3);
      check("t1_q_empty", exp_q.size(), 0);

      // 2: JNZ loop, 4 + 3 x (4 + 3) + 2 cycles
      rom[0] = enc(4'h5, 4'd1, 4'd0, 4'd0, 8'd3);   // ADDI r1,r0,3
      rom[1] = enc(4'h6, 4'd1, 4'd1, 4'd0, 8'd1);   // SUBI r1,r1,1
      rom[2] = enc(4'h8, 4'd0, 4'd1, 4'd0, 8'd1);   // JNZ  r1,1
      rom[3] = enc(4'hF, 4'd0, 4'd0, 4'd0, 8'd0);   // HALT
      exp_q.push_back({4'd1, 8'd3});
      exp_q.push_back({4'd1, 8'd2});
      exp_q.push_back({4'd1, 8'd1});
      exp_q.push_back({4'd1, 8'd0});
      wr_cnt = 0;
      do_start();
      wait_done("t2", 27);
      check("t2_r1", regs[1], 0);
      check("t2_wr_cnt", wr_cnt, 4);
      check("t2_q_empty", exp_q.size(), 0);

      // 3: illegal opcode, then restart clears error
      rom[0] = 24'h9ABCDE;
      wr_cnt = 0;
      do_start();
      wait_done("t3", 2);
      check("t3_error_set", error, 1);
      check("t3_wr_cnt", wr_cnt, 0);
      do_start();
      wait_done("t3b", 2);
      check("t3b_error_set", error, 1);

      // 4: JMP 255 -> NOP -> pc wraps to 0 (ROM[0] replaced by HALT)
      rom[0] = enc(4'h7, 4'd0, 4'd0, 4'd0, 8'hFF);
      rom[1] = 24'h0; rom[2] = 24'h0; rom[3] = 24'h0;
      rom[255] = 24'h0;
      wr_cnt = 0;
      do_start();
      n = 0;
      while (imem_addr !== 8'hFF && n < 50) begin @(negedge clk); n++; end
      check("t4_jump_target", imem_addr, 8'hFF);
      rom[0] = enc(4'hF, 4'd0, 4'd0, 4'd0, 8'd0);
      n = 0;
      while (imem_addr === 8'hFF && n < 50) begin @(negedge clk); n++; end
      check("t4_wrap", imem_addr, 0);
      wait_done("t4", 8);
      check("t4_wr_cnt", wr_cnt, 0);

      // 5: start pulsed mid-run is ignored
      load_prog1();
      exp_q.push_back({4'd1, 8'd5});
      exp_q.push_back({4'd2, 8'd3});
      exp_q.push_back({4'd3, 8'd8});
      do_start();
      n = 0;
      while (imem_addr !== 8'd2 && n < 50) begin @(negedge clk); n++; end
      check("t5_at_pc2", imem_addr, 2);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("t5_busy_kept", busy, 1);
      check("t5_pc_kept", imem_addr, 2);
      wait_done("t5", 14);
      check("t5_pc_end", imem_addr, 3);
      check("t5_r3", regs[3], 8);
      check("t5_q_empty", exp_q.size(), 0);

      // 6: reset asserted during WRITE
      exp_q.push_back({4'd1, 8'd5});
      wr_cnt = 0;
      done_seen = 1'b0;
      do_start();
      n = 0;
      while (RegWrite !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      check("t6_in_write", RegWrite, 1);
      #1 reset = 1'b0;
      #1;
      check("t6_regwrite_async", RegWrite, 0);
      check("t6_busy_async", busy, 0);
      check("t6_pc_async", imem_addr, 0);
      check("t6_done_async", done, 0);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      check("t6_idle", busy, 0);
      check("t6_no_done", done_seen, 0);
      check("t6_wr_cnt", wr_cnt, 1);
      check("t6_q_empty", exp_q.size(), 0);

      // Full run again after the mid-run reset
      exp_q.push_back({4'd1, 8'd5});
      exp_q.push_back({4'd2, 8'd3});
      exp_q.push_back({4'd3, 8'd8});
      do_start();
      wait_done("t7", 14);
      check("t7_r3", regs[3], 8);
      check("t7_q_empty", exp_q.size(), 0);
      check("unexpected_writes", unexpected_wr, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule : tb_alu_ctrl_sequencer

`default_nettype wire
